fir_axis_out: RTL and testbench
===============================

Name: fir_axis_out

Overview:
- Downstream drain stage of the FIR output FIFO.
- Pops FIR result words from the FIFO (fifo_empty / r_ready / data_out interface) and presents them as an AXI-Stream master (m_axis_*).
- Counts beats against a per-transfer length, asserts tlast on the final beat, and reports completion to the AXI-Lite control block.
- A 2-entry output buffer gives full throughput and keeps m_axis_tready off the FIFO pop path.

Parameters:
- WIDTH, 32, data width; must equal the FIFO WIDTH.
- LEN_W, 16, width of the transfer length and beat counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- ap_start  in  1  single-cycle pulse; starts a transfer. Honoured only in IDLE.
- cfg_len  in  LEN_W  number of beats to stream; sampled on an accepted ap_start.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse when the transfer completes.
- fifo_empty  in  1  FIFO status.
- fifo_r_ready  out  1  pop request; drives the FIFO r_ready input.
- fifo_data  in  WIDTH  FIFO data_out. Combinational; valid in the same cycle as the pop.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tdata  out  WIDTH  AXI-Stream data.
- m_axis_tlast  out  1  high on the last beat of a transfer.

Behaviour:
- Reset values:
  - state IDLE.
  - ap_idle=1, ap_done=0, fifo_r_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - Counters, buffer entries and buffer count all cleared.
- States: IDLE, STREAM, DONE.
- IDLE:
  - ap_start with cfg_len!=0: latch len, clear pop_cnt and out_cnt, go to STREAM.
  - ap_start with cfg_len==0: go to DONE; no beats are sent.
- STREAM:
  - fifo_r_ready = !fifo_empty && pop_cnt!=len && buf_cnt<2. Uses registered state only; no path from m_axis_tready.
  - Pop: fifo_r_ready=1. Write {fifo_data, pop_cnt==len-1} into the buffer tail in the same cycle; pop_cnt increments.
  - Output: the head entry drives tdata and tlast. m_axis_tvalid = (buf_cnt!=0).
  - Handshake (tvalid&&tready): drop the head; out_cnt increments.
  - Push and handshake in the same cycle: buf_cnt is unchanged and order is preserved.
  - tdata and tlast hold stable while tvalid=1 and tready=0 (AXI rule).
  - Handshake on a head with tlast=1: go to DONE.
- DONE:
  - ap_done=1 for exactly one cycle, then IDLE.
  - ap_idle=0 in STREAM and DONE.
- Latency and throughput:
  - First pop occurs in the cycle after start, if the FIFO is non-empty.
  - First tvalid one cycle after the first pop.
  - Sustained 1 beat/cycle when the FIFO never empties and tready stays 1.
- Boundaries:
  - ap_start in STREAM or DONE is ignored; cfg_len changes after start have no effect.
  - FIFO empty mid-transfer: no pop. tvalid drops once the buffer drains and resumes when data arrives.
  - len = 2^LEN_W-1 is supported; counters never wrap within one transfer.
  - No extra pops after pop_cnt==len; FIFO words beyond len stay in the FIFO for the next transfer.
  - rst mid-transfer: immediate return to reset values; buffered data is discarded. FIFO contents are not affected by this block.

Decomposition:
- Package fir_axis_pkg holds:
  - state enum (IDLE, STREAM, DONE);
  - LEN_W default;
  - buffer entry struct {data, last}.
- One sub-module: fir_axis_skid. A 2-entry, registered-ready buffer with push/pop and count; the top holds the FSM and counters.

Test Plan:
- FIFO preloaded with 0x11..0x14, cfg_len=4, tready=1 → 4 consecutive beats 0x11..0x14; tlast only on 0x14; ap_done one cycle later; ap_idle=1 after.
- cfg_len=3, tready toggles 1,0,0,1,... → no beat lost or duplicated; tdata stable while stalled; fifo_r_ready=0 whenever buf_cnt=2.
- FIFO empty for 5 cycles mid-transfer (len=6) → tvalid gaps; the 6 beats arrive in order; exactly 6 pops total.
- cfg_len=0 start → ap_done pulse within 2 cycles; zero pops, tvalid never asserted.
- ap_start pulsed during STREAM with a different cfg_len → ignored; original length completes.
- rst asserted after beat 2 of 8 → all outputs return to reset values asynchronously; a new start with len=2 streams the next FIFO words correctly.

Source files
------------

// File: rtl/fir_axis_pkg.sv
// -----------------------------------------------------------------------------
// fir_axis_pkg
// Shared types and defaults for the FIR output drain stage.
//   state_t      : drain FSM states
//   buf_entry_t  : one output-buffer slot at the default data width
//   LEN_W_DEF    : default width of the transfer length / beat counters
//   WIDTH_DEF    : default data width (matches the FIR output FIFO)
// -----------------------------------------------------------------------------
package fir_axis_pkg;

    localparam int LEN_W_DEF = 16;
    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] data;
        logic                 last;
    } buf_entry_t;

endpackage

// File: rtl/fir_axis_out_if.sv
// -----------------------------------------------------------------------------
// fir_axis_out_if
// Bundles the control, FIFO-side and AXI-Stream signals of the drain stage.
//   Control : ap_start, cfg_len (in)  / ap_idle, ap_done (out)
//   FIFO    : fifo_empty, fifo_data (in) / fifo_r_ready (out, pop request)
//   AXIS    : m_axis_tready (in) / m_axis_tvalid, m_axis_tdata, m_axis_tlast
// Modport master is the drain stage; modport slave is its environment.
// -----------------------------------------------------------------------------
interface fir_axis_out_if
    import fir_axis_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
);

    logic             ap_start;
    logic [LEN_W-1:0] cfg_len;
    logic             ap_idle;
    logic             ap_done;

    logic             fifo_empty;
    logic             fifo_r_ready;
    logic [WIDTH-1:0] fifo_data;

    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tlast;

    modport master (
        input  ap_start,
        input  cfg_len,
        output ap_idle,
        output ap_done,
        input  fifo_empty,
        input  fifo_data,
        output fifo_r_ready,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdata,
        output m_axis_tlast
    );

    modport slave (
        output ap_start,
        output cfg_len,
        input  ap_idle,
        input  ap_done,
        output fifo_empty,
        output fifo_data,
        input  fifo_r_ready,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tlast
    );

endinterface

// File: rtl/fir_axis_skid.sv
// -----------------------------------------------------------------------------
// fir_axis_skid
// Two-entry in-order buffer between the FIFO pop and the AXI-Stream output.
// The producer decides whether it may push from o_count alone (registered),
// so the downstream ready never reaches the FIFO pop logic.
//   clk, rst      : clock, asynchronous active-high reset
//   i_push        : write i_push_entry at the tail (only when o_count < 2)
//   i_push_entry  : entry to store
//   i_pop         : drop the head entry (only when o_count != 0)
//   o_head        : current head entry (stale contents when empty)
//   o_count       : number of valid entries, 0..2
// -----------------------------------------------------------------------------
module fir_axis_skid
    import fir_axis_pkg::*;
#(
    parameter type entry_t = buf_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  entry_t     i_push_entry,
    input  logic       i_pop,
    output entry_t     o_head,
    output logic [1:0] o_count
);

    entry_t     r_mem [2];
    logic       r_head;
    logic [1:0] r_count;
    logic       w_tail;

    // With at most two entries the tail is the head slot when empty and the
    // other slot when one entry is held; a push never happens when full.
    assign w_tail = r_head ^ r_count[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[w_tail] <= i_push_entry;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/fir_axis_out.sv
// -----------------------------------------------------------------------------
// fir_axis_out
// Drain stage of the FIR output FIFO: pops result words and streams them as
// an AXI-Stream master, marking the final beat of each transfer with tlast
// and pulsing ap_done when the final beat has been accepted.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   io_bus  : fir_axis_out_if.master
//             ap_start/cfg_len/ap_idle/ap_done  - control handshake
//             fifo_empty/fifo_data/fifo_r_ready - FIFO read port
//             m_axis_tvalid/tready/tdata/tlast  - AXI-Stream output
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for ap_start; ap_idle high
// STREAM | popping up to len words and streaming them out
// DONE   | one-cycle ap_done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module fir_axis_out
    import fir_axis_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    fir_axis_out_if.master io_bus
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_pop_cnt;
    logic [LEN_W-1:0] r_out_cnt;

    logic             w_start;
    logic             w_pop;
    logic             w_tvalid;
    logic             w_hs;
    entry_t           w_push_entry;
    entry_t           w_head;
    logic [1:0]       w_buf_cnt;

    assign w_start  = (r_state == IDLE) && io_bus.ap_start;
    assign w_tvalid = (w_buf_cnt != 2'd0);
    assign w_hs     = w_tvalid && io_bus.m_axis_tready;

    // Pop decision only looks at registered state and the FIFO status, so
    // m_axis_tready has no combinational path to the FIFO read port.
    assign w_pop = (r_state == STREAM) && !io_bus.fifo_empty &&
                   (r_pop_cnt != r_len) && (w_buf_cnt != 2'd2);

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.data = io_bus.fifo_data;
        w_push_entry.last = (r_pop_cnt == (r_len - LEN_W'(1)));
    end

    fir_axis_skid #(
        .entry_t (entry_t)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_pop),
        .i_push_entry (w_push_entry),
        .i_pop        (w_hs),
        .o_head       (w_head),
        .o_count      (w_buf_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (io_bus.ap_start) begin
                    w_state_nxt = (io_bus.cfg_len != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (w_hs && w_head.last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= '0;
            r_pop_cnt <= '0;
            r_out_cnt <= '0;
        end else if (w_start) begin
            r_len     <= io_bus.cfg_len;
            r_pop_cnt <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_pop_cnt <= r_pop_cnt + LEN_W'(1);
            end
            if (w_hs) begin
                r_out_cnt <= r_out_cnt + LEN_W'(1);
            end
        end
    end

    assign io_bus.ap_idle       = (r_state == IDLE);
    assign io_bus.ap_done       = (r_state == DONE);
    assign io_bus.fifo_r_ready  = w_pop;
    assign io_bus.m_axis_tvalid = w_tvalid;
    assign io_bus.m_axis_tdata  = w_head.data;
    // A drained buffer still holds the previous final entry; keep tlast low
    // whenever nothing is being presented.
    assign io_bus.m_axis_tlast  = w_head.last && w_tvalid;

endmodule

// File: tb/tb_fir_axis_out.sv
module tb_fir_axis_out;

    localparam int WIDTH = 32;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic rst;

    fir_axis_out_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    fir_axis_out #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] all_words[$];

    // transfer-level reference model
    bit m_busy;
    int m_len, m_base, m_pops, m_beats, m_done_cyc;
    int g_pops, g_beats, g_done, gap_cnt, first_hs_cyc, last_hs_cyc;
    int tready_mode, pat_idx;
    bit feed_rand, pop_seen;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic fifo_push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        all_words.push_back(w);
        drive_fifo();
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_len      = 0;
        m_base     = g_pops;
        m_pops     = 0;
        m_beats    = 0;
        m_done_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_idle"},   bus.ap_idle, 1);
        check_val({tag, "_done"},   bus.ap_done, 0);
        check_val({tag, "_rready"}, bus.fifo_r_ready, 0);
        check_val({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
        check_val({tag, "_tlast"},  bus.m_axis_tlast, 0);
        check_val({tag, "_tdata"},  bus.m_axis_tdata, 0);
    endtask

    // Called mid-cycle: compare outputs with the model, then advance the
    // model by what happens at the coming rising edge.
    task automatic monitor();
        int               occ;
        int               idx;
        bit               hs;
        bit               was_busy;
        logic [WIDTH-1:0] exp_d;
        occ      = m_pops - m_beats;
        was_busy = m_busy;
        check_val("ap_idle", bus.ap_idle, !m_busy);
        check_val("ap_done", bus.ap_done, (cyc == m_done_cyc));
        check_val("tvalid", bus.m_axis_tvalid, (occ != 0));
        check_val("r_ready", bus.fifo_r_ready,
                  m_busy && (fifo_q.size() != 0) && (m_pops < m_len) && (occ < 2));
        if (occ != 0) begin
            idx   = m_base + m_beats;
            exp_d = (idx < all_words.size()) ? all_words[idx] : '0;
            check_val("tdata", bus.m_axis_tdata, exp_d);
            check_val("tlast", bus.m_axis_tlast, (m_beats == m_len - 1));
        end
        if (bus.ap_done) g_done++;
        if (m_busy && m_beats > 0 && m_beats < m_len && !bus.m_axis_tvalid) gap_cnt++;
        pop_seen = bus.fifo_r_ready && (fifo_q.size() != 0);
        hs       = bus.m_axis_tvalid && bus.m_axis_tready;
        if (pop_seen) begin
            m_pops++;
            g_pops++;
        end
        if (was_busy && cyc == m_done_cyc) m_busy = 1'b0;
        if (hs) begin
            if (m_beats == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            m_beats++;
            g_beats++;
            if (m_beats == m_len) m_done_cyc = cyc + 1;
        end
        if (bus.ap_start && !was_busy && !rst) begin
            m_busy     = 1'b1;
            m_len      = int'(bus.cfg_len);
            m_base     = g_pops;
            m_pops     = 0;
            m_beats    = 0;
            m_done_cyc = (m_len == 0) ? cyc + 1 : -1;
        end
    endtask

    task automatic tick();
        logic [WIDTH-1:0] dropped;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (pop_seen) dropped = fifo_q.pop_front();
        cyc++;
        case (tready_mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = (pat_idx % 3 == 0);
            2:       bus.m_axis_tready = 1'($urandom_range(0, 1));
            default: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
        pat_idx++;
        if (feed_rand && fifo_q.size() < 6 && $urandom_range(0, 2) != 0) fifo_push($urandom);
        drive_fifo();
    endtask

    task automatic start_xfer(input int len);
        bus.ap_start = 1'b1;
        bus.cfg_len  = LEN_W'(len);
        tick();
        bus.ap_start = 1'b0;
        bus.cfg_len  = LEN_W'($urandom);
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_timeout"}, m_busy, 0);
    endtask

    int p0, b0, d0, n;

    initial begin
        rst               = 1'b0;
        bus.ap_start      = 1'b0;
        bus.cfg_len       = '0;
        bus.m_axis_tready = 1'b0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_data     = '0;
        g_pops = 0; g_beats = 0; g_done = 0; gap_cnt = 0;
        first_hs_cyc = 0; last_hs_cyc = 0;
        tready_mode = 0; pat_idx = 0; feed_rand = 1'b0; pop_seen = 1'b0;
        model_reset();

        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back burst of four preloaded words
        tready_mode       = 0;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) fifo_push(WIDTH'(32'h11 + i));
        p0 = g_pops;
        start_xfer(4);
        run_until_idle(20, "t1");
        check_val("t1_burst_span", last_hs_cyc - first_hs_cyc, 3);
        check_val("t1_pops", g_pops - p0, 4);
        tick();
        check_val("t1_idle_after", bus.ap_idle, 1);

        // stalled sink, tready 1,0,0,1,0,0...
        tready_mode = 1;
        pat_idx     = 0;
        for (int i = 0; i < 4; i++) fifo_push($urandom);
        p0 = g_pops;
        b0 = g_beats;
        start_xfer(3);
        run_until_idle(40, "t2");
        check_val("t2_beats", g_beats - b0, 3);
        check_val("t2_pops", g_pops - p0, 3);

        // FIFO runs dry mid-transfer
        tready_mode = 0;
        fifo_push($urandom);
        p0      = g_pops;
        gap_cnt = 0;
        start_xfer(6);
        repeat (8) tick();
        for (int i = 0; i < 4; i++) fifo_push($urandom);
        run_until_idle(30, "t3");
        check_val("t3_gap_seen", (gap_cnt != 0), 1);
        check_val("t3_pops", g_pops - p0, 6);

        // zero-length transfer leaves the FIFO untouched
        fifo_push($urandom);
        fifo_push($urandom);
        p0 = g_pops;
        d0 = g_done;
        start_xfer(0);
        run_until_idle(3, "t4");
        check_val("t4_pops", g_pops - p0, 0);
        check_val("t4_done_pulses", g_done - d0, 1);

        // ap_start during STREAM is ignored
        tready_mode = 2;
        for (int i = 0; i < 5; i++) fifo_push($urandom);
        p0 = g_pops;
        b0 = g_beats;
        start_xfer(5);
        repeat (2) tick();
        bus.ap_start = 1'b1;
        bus.cfg_len  = LEN_W'(2);
        tick();
        bus.ap_start = 1'b0;
        run_until_idle(80, "t5");
        check_val("t5_beats", g_beats - b0, 5);
        check_val("t5_pops", g_pops - p0, 5);

        // reset after two beats of an eight-beat transfer
        tready_mode = 0;
        for (int i = 0; i < 8; i++) fifo_push($urandom);
        start_xfer(8);
        n = 0;
        while (m_beats < 2 && n < 20) begin
            tick();
            n++;
        end
        check_val("t6_reach_beat2", m_beats, 2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t6_reset");
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        b0  = g_beats;
        start_xfer(2);
        run_until_idle(20, "t6_restart");
        check_val("t6_beats", g_beats - b0, 2);

        // randomized transfers with a trickling FIFO and random sink
        feed_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tready_mode = 2 + (t % 2);
            b0 = g_beats;
            n  = $urandom_range(1, 9);
            start_xfer(n);
            run_until_idle(300, "rand");
            check_val("rand_beats", g_beats - b0, n);
            repeat ($urandom_range(0, 3)) tick();
        end
        feed_rand = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
